// File: rtl/vectored_int_ctrl.sv
// Vectored, prioritised interrupt controller with an in-service stack feeding the CPU control unit.
// Build option VIC_NESTING_EN: when defined, nesting/preemption up to NEST_DEPTH; otherwise depth is 1.
module vectored_int_ctrl #(
    parameter int                   NUM_IRQ    = 8,
    parameter int                   VEC_WIDTH  = 16,
    parameter logic [VEC_WIDTH-1:0] VEC_BASE   = 16'h0010,
    parameter int                   VEC_STRIDE = 2,
    parameter int                   NEST_DEPTH = 4,
    localparam int                  IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    localparam int                  NLW        = $clog2(NEST_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq_in,
    input  logic                 en_wr,
    input  logic [NUM_IRQ-1:0]   en_data,
    output logic [NUM_IRQ-1:0]   en_q,
    output logic [NUM_IRQ-1:0]   pending,
    output logic                 int_req,
    output logic [VEC_WIDTH-1:0] int_vector,
    input  logic                 int_ack_attended,
    input  logic                 int_ack_complete,
    output logic [IDW-1:0]       active_id,
    output logic                 in_service,
    output logic [NLW-1:0]       nest_level
);

`ifdef VIC_NESTING_EN
    localparam int EFF_DEPTH = NEST_DEPTH;
`else
    localparam int EFF_DEPTH = 1;
`endif
    // Stack storage is sized to the full index range of nest_level so every index is in bounds.
    localparam int STK_SIZE = 2 ** NLW;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t               state_r;
    logic [NUM_IRQ-1:0]   irq_prev_r;
    logic [NUM_IRQ-1:0]   pending_r;
    logic [NUM_IRQ-1:0]   en_q_r;
    logic                 int_req_r;
    logic [VEC_WIDTH-1:0] int_vector_r;
    logic [IDW-1:0]       req_id_r;
    logic [IDW-1:0]       active_id_r;
    logic                 in_service_r;
    logic [NLW-1:0]       nest_level_r;
    logic [IDW-1:0]       stack_r [STK_SIZE];

    logic [NUM_IRQ-1:0]   edge_s;
    logic [NUM_IRQ-1:0]   hit_s;
    logic [NUM_IRQ-1:0]   clr_mask_s;
    logic                 cand_valid_s;
    logic [IDW-1:0]       cand_id_s;
    logic                 stack_empty_s;
    logic                 room_s;
    logic                 eligible_s;
    logic [VEC_WIDTH-1:0] vec_s;
    logic                 push_s;
    logic                 pop_s;
    logic [NLW-1:0]       level_next_s;

    assign edge_s        = irq_in & ~irq_prev_r;
    assign hit_s         = pending_r & en_q_r;
    assign stack_empty_s = (nest_level_r == {NLW{1'b0}});
    assign room_s        = (nest_level_r < NLW'(EFF_DEPTH));
    assign push_s        = (state_r == S_REQ) && int_ack_attended;
    assign pop_s         = int_ack_complete && !stack_empty_s;
    assign clr_mask_s    = push_s ? (NUM_IRQ'(1'b1) << req_id_r) : {NUM_IRQ{1'b0}};
    assign vec_s         = VEC_BASE + (VEC_WIDTH'(cand_id_s) * VEC_WIDTH'(VEC_STRIDE));

    // Fixed-priority encoder: the downward scan leaves the lowest enabled pending index.
    always_comb begin
        cand_valid_s = 1'b0;
        cand_id_s    = {IDW{1'b0}};
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            cand_id_s    = hit_s[i] ? IDW'(i) : cand_id_s;
            cand_valid_s = cand_valid_s | hit_s[i];
        end
    end

    // A candidate may preempt only a strictly lower-priority handler and only with stack room left.
    always_comb begin
        eligible_s = 1'b0;
        if (!cand_valid_s) begin
            eligible_s = 1'b0;
        end else if (stack_empty_s) begin
            eligible_s = 1'b1;
        end else begin
            eligible_s = (cand_id_s < active_id_r) && room_s;
        end
    end

    // Occupancy after this edge: a simultaneous pop and push leaves the level unchanged.
    always_comb begin
        level_next_s = nest_level_r;
        case ({push_s, pop_s})
            2'b10: begin
                if (room_s) begin
                    level_next_s = nest_level_r + NLW'(1);
                end else begin
                    level_next_s = nest_level_r;
                end
            end
            2'b01:   level_next_s = nest_level_r - NLW'(1);
            default: level_next_s = nest_level_r;
        endcase
    end

    // Request FSM: the request is frozen in S_REQ until the control unit attends it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            int_req_r    <= 1'b0;
            int_vector_r <= {VEC_WIDTH{1'b0}};
            req_id_r     <= {IDW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (eligible_s) begin
                        state_r      <= S_REQ;
                        int_req_r    <= 1'b1;
                        int_vector_r <= vec_s;
                        req_id_r     <= cand_id_s;
                    end
                end
                S_REQ: begin
                    if (int_ack_attended) begin
                        state_r      <= S_IDLE;
                        int_req_r    <= 1'b0;
                        int_vector_r <= {VEC_WIDTH{1'b0}};
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    int_req_r    <= 1'b0;
                    int_vector_r <= {VEC_WIDTH{1'b0}};
                    req_id_r     <= {IDW{1'b0}};
                end
            endcase
        end
    end

    // Edge capture, enable mask and pending bits; a new edge outranks the acknowledge clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev_r <= {NUM_IRQ{1'b0}};
            en_q_r     <= {NUM_IRQ{1'b0}};
            pending_r  <= {NUM_IRQ{1'b0}};
        end else begin
            irq_prev_r <= irq_in;
            if (en_wr) begin
                en_q_r <= en_data;
            end
            pending_r <= (pending_r & ~clr_mask_s) | edge_s;
        end
    end

    // In-service stack; active_id mirrors the top entry so it can be driven from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STK_SIZE; i++) begin
                stack_r[i] <= {IDW{1'b0}};
            end
            active_id_r  <= {IDW{1'b0}};
            nest_level_r <= {NLW{1'b0}};
            in_service_r <= 1'b0;
        end else begin
            nest_level_r <= level_next_s;
            in_service_r <= (level_next_s != {NLW{1'b0}});
            case ({push_s, pop_s})
                2'b11: begin
                    stack_r[nest_level_r - NLW'(1)] <= req_id_r;
                    active_id_r                     <= req_id_r;
                end
                2'b10: begin
                    if (room_s) begin
                        stack_r[nest_level_r] <= req_id_r;
                        active_id_r           <= req_id_r;
                    end
                end
                2'b01: begin
                    active_id_r <= (nest_level_r > NLW'(1)) ? stack_r[nest_level_r - NLW'(2)]
                                                            : {IDW{1'b0}};
                end
                default: begin
                    active_id_r <= active_id_r;
                end
            endcase
        end
    end

    assign en_q       = en_q_r;
    assign pending    = pending_r;
    assign int_req    = int_req_r;
    assign int_vector = int_vector_r;
    assign active_id  = active_id_r;
    assign in_service = in_service_r;
    assign nest_level = nest_level_r;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Bench for vectored_int_ctrl: directed vector table, hand-written nesting sequences and a
// randomized run against a queue-based reference model.
module tb_vectored_int_ctrl;

`ifdef VIC_NESTING_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        en_wr;
    logic [7:0]  en_data;
    logic [7:0]  en_q;
    logic [7:0]  pending;
    logic        int_req;
    logic [15:0] int_vector;
    logic        int_ack_attended;
    logic        int_ack_complete;
    logic [2:0]  active_id;
    logic        in_service;
    logic [2:0]  nest_level;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit [7:0] m_pend, m_en, m_prev;
    bit       m_req;
    int       m_rid;
    int       m_stk[$];

    typedef struct {
        bit        rst;
        bit [7:0]  irq;
        bit        ew;
        bit [7:0]  ed;
        bit        a;
        bit        c;
        bit        req;
        bit [15:0] vec;
        bit [7:0]  pend;
        bit [7:0]  en;
        bit        ins;
        bit [2:0]  act;
        bit [2:0]  lvl;
    } vec_t;
    vec_t tbl[$];

    vectored_int_ctrl dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .en_wr(en_wr), .en_data(en_data),
        .en_q(en_q), .pending(pending), .int_req(int_req), .int_vector(int_vector),
        .int_ack_attended(int_ack_attended), .int_ack_complete(int_ack_complete),
        .active_id(active_id), .in_service(in_service), .nest_level(nest_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit [7:0] irq, input bit ew, input bit [7:0] ed,
                              input bit a, input bit c);
        int       cand;
        bit       elig, push, pop;
        bit [7:0] np;
        if (r) begin
            m_pend = 8'h00; m_en = 8'h00; m_prev = 8'h00; m_req = 1'b0; m_rid = 0;
            m_stk.delete();
        end else begin
            cand = -1;
            for (int i = 0; i < 8; i++) begin
                if (m_pend[i] && m_en[i]) begin
                    cand = i;
                    break;
                end
            end
            elig = (cand >= 0) && (m_stk.size() == 0 ||
                                   (cand < m_stk[$] && m_stk.size() < DEPTH));
            push = m_req && a;
            pop  = c && (m_stk.size() > 0);
            np   = m_pend;
            if (push) np[m_rid] = 1'b0;
            np = np | (irq & ~m_prev);
            if (pop)  void'(m_stk.pop_back());
            if (push) m_stk.push_back(m_rid);
            if (m_req) begin
                if (push) m_req = 1'b0;
            end else if (elig) begin
                m_req = 1'b1;
                m_rid = cand;
            end
            m_pend = np;
            if (ew) m_en = ed;
            m_prev = irq;
        end
    endtask

    task automatic model_check();
        chk("m_int_req", int_req, m_req);
        if (m_req) chk("m_int_vector", int_vector, 16'(16'h0010 + m_rid * 2));
        chk("m_pending", pending, m_pend);
        chk("m_en_q", en_q, m_en);
        chk("m_in_service", in_service, m_stk.size() != 0);
        chk("m_nest_level", nest_level, m_stk.size());
        chk("m_active_id", active_id, (m_stk.size() != 0) ? m_stk[$] : 0);
    endtask

    task automatic cyc(input bit r, input bit [7:0] irq, input bit ew, input bit [7:0] ed,
                       input bit a, input bit c);
        rst = r; irq_in = irq; en_wr = ew; en_data = ed;
        int_ack_attended = a; int_ack_complete = c;
        @(posedge clk);
        model_edge(r, irq, ew, ed, a, c);
        #1;
        model_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; irq_in = 8'h00; en_wr = 1'b0; en_data = 8'h00;
        int_ack_attended = 1'b0; int_ack_complete = 1'b0;

        //                rst irq    ew  ed     a  c   req vec       pend   en     ins act   lvl
        tbl.push_back('{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h08, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0016, 8'h08, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b1, 3'd3, 3'd1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h20, 8'h00, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h20, 8'h00, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h20, 8'h20, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h001A, 8'h20, 8'h20, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h20, 1'b1, 3'd5, 3'd1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h20, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h44, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0014, 8'h44, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h40, 8'hFF, 1'b1, 3'd2, 3'd1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h40, 8'hFF, 1'b1, 3'd2, 3'd1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h40, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h001C, 8'h40, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b1, 3'd6, 3'd1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b0, 3'd0, 3'd0});
        // re-trigger on the attended cycle keeps the bit pending
        tbl.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h08, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0016, 8'h08, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h08, 8'hFF, 1'b1, 3'd3, 3'd1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h08, 8'hFF, 1'b1, 3'd3, 3'd1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h08, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0016, 8'h08, 8'hFF, 1'b0, 3'd0, 3'd0});
        // reset while a request is outstanding
        tbl.push_back('{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0});
        // stray attended and complete with nothing outstanding
        tbl.push_back('{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b0, 3'd0, 3'd0});
        // frozen request: mask change and higher-priority edge do not disturb it
        tbl.push_back('{1'b0, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h04, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0014, 8'h04, 8'hFF, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0014, 8'h04, 8'h00, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0014, 8'h05, 8'h00, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h01, 8'h00, 1'b1, 3'd2, 3'd1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h01, 8'h00, 1'b0, 3'd0, 3'd0});

        for (int k = 0; k < tbl.size(); k++) begin
            cyc(tbl[k].rst, tbl[k].irq, tbl[k].ew, tbl[k].ed, tbl[k].a, tbl[k].c);
            chk($sformatf("row%0d_req", k), int_req, tbl[k].req);
            if (tbl[k].req) chk($sformatf("row%0d_vec", k), int_vector, tbl[k].vec);
            chk($sformatf("row%0d_pend", k), pending, tbl[k].pend);
            chk($sformatf("row%0d_en", k), en_q, tbl[k].en);
            chk($sformatf("row%0d_ins", k), in_service, tbl[k].ins);
            chk($sformatf("row%0d_act", k), active_id, tbl[k].act);
            chk($sformatf("row%0d_lvl", k), nest_level, tbl[k].lvl);
        end

        // handler for id 4 in service, then id 0 fires
        cyc(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
        cyc(1'b0, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(1);
        chk("h_req4", int_req, 1'b1);
        chk("h_vec4", int_vector, 16'h0018);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("h_act4", active_id, 3'd4);
`ifdef VIC_NESTING_EN
        cyc(1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(1);
        chk("n_req1", int_req, 1'b1);
        chk("n_vec1", int_vector, 16'h0012);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("n_lvl2", nest_level, 3'd2);
        chk("n_act1", active_id, 3'd1);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("n_act_back4", active_id, 3'd4);
        // preempt again and complete the outer handler on the attended cycle
        cyc(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(1);
        chk("n_req0", int_req, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("n_swap_lvl", nest_level, 3'd1);
        chk("n_swap_act", active_id, 3'd0);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("n_empty", in_service, 1'b0);
        // fill the stack with 7,5,3,1 then id 0 must wait for a complete
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 8'h80 >> (2 * j), 1'b0, 8'h00, 1'b0, 1'b0);
            idle(1);
            cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("f_lvl4", nest_level, 3'd4);
        chk("f_act1", active_id, 3'd1);
        cyc(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(3);
        chk("f_noreq", int_req, 1'b0);
        chk("f_pend0", pending, 8'h01);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(1);
        chk("f_req0", int_req, 1'b1);
        chk("f_vec0", int_vector, 16'h0010);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int j = 0; j < 5; j++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("f_lvl0", nest_level, 3'd0);
`else
        cyc(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        chk("o_noreq", int_req, 1'b0);
        chk("o_pend0", pending, 8'h01);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("o_ins0", in_service, 1'b0);
        idle(1);
        chk("o_req0", int_req, 1'b1);
        chk("o_vec0", int_vector, 16'h0010);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("o_lvl0", nest_level, 3'd0);
`endif

        // randomized traffic against the reference model
        cyc(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 399) == 0),
                8'($urandom & $urandom & $urandom),
                ($urandom_range(0, 19) == 0),
                8'($urandom | $urandom),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
